// File: rtl/polyshift_r_flags_stage_if.sv
// polyshift_r_flags_stage_if
// Bundles the upstream (s_*) and downstream (m_*) valid/ready beat streams of
// the right-polyshift flags stage.
//   s_valid_i / s_ready_o      upstream handshake
//   s_data_i, s_cf_i           shifted word and its carry flag
//   s_flags_we_i               beat commits its flags when it retires
//   m_valid_o / m_ready_i      downstream handshake
//   m_data_o, m_cf_o, m_zf_o, m_sf_o   buffered word and per-beat flags
//   m_pf_o                     per-beat parity flag (POLYSHIFT_R_FLAGS_STAGE_PF_EN only)
// Modports: slave = the stage itself, master = the surrounding environment.
interface polyshift_r_flags_stage_if #(
  parameter int WORD_WIDTH = 8
);
  logic                  s_valid_i;
  logic                  s_ready_o;
  logic [WORD_WIDTH-1:0] s_data_i;
  logic                  s_cf_i;
  logic                  s_flags_we_i;
  logic                  m_valid_o;
  logic                  m_ready_i;
  logic [WORD_WIDTH-1:0] m_data_o;
  logic                  m_cf_o;
  logic                  m_zf_o;
  logic                  m_sf_o;
`ifdef POLYSHIFT_R_FLAGS_STAGE_PF_EN
  logic                  m_pf_o;
`endif

  modport slave (
    input  s_valid_i, s_data_i, s_cf_i, s_flags_we_i, m_ready_i,
    output s_ready_o, m_valid_o, m_data_o, m_cf_o, m_zf_o, m_sf_o
`ifdef POLYSHIFT_R_FLAGS_STAGE_PF_EN
    , output m_pf_o
`endif
  );

  modport master (
    output s_valid_i, s_data_i, s_cf_i, s_flags_we_i, m_ready_i,
    input  s_ready_o, m_valid_o, m_data_o, m_cf_o, m_zf_o, m_sf_o
`ifdef POLYSHIFT_R_FLAGS_STAGE_PF_EN
    , input m_pf_o
`endif
  );
endinterface

// File: rtl/polyshift_r_flags_stage.sv
// polyshift_r_flags_stage
// Registered output stage behind the right polyshift datapath. Each accepted
// word gets zero/sign flags (and optionally parity) attached, is held in a
// two-entry skid buffer (main + skid), and on retire a flag-writing beat
// loads the architectural flag register.
// Ports:
//   clk_i            clock, rising edge
//   rst_n_i          asynchronous active-low reset
//   bus (slave)      s_* input stream, m_* output stream (see interface)
//   cf_q_o, zf_q_o, sf_q_o   architectural flag register
//   pf_q_o           architectural parity flag (macro only)
// Optional feature: define POLYSHIFT_R_FLAGS_STAGE_PF_EN to add the parity flag.
module polyshift_r_flags_stage #(
  parameter int WORD_WIDTH = 8
) (
  input  logic clk_i,
  input  logic rst_n_i,
  polyshift_r_flags_stage_if.slave bus,
  output logic cf_q_o,
  output logic zf_q_o,
`ifdef POLYSHIFT_R_FLAGS_STAGE_PF_EN
  output logic sf_q_o,
  output logic pf_q_o
`else
  output logic sf_q_o
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] data;
    logic                  cf;
    logic                  zf;
    logic                  sf;
    logic                  we;
`ifdef POLYSHIFT_R_FLAGS_STAGE_PF_EN
    logic                  pf;
`endif
  } beat_t;

`ifdef POLYSHIFT_R_FLAGS_STAGE_PF_EN
  // Even parity: 1 when the word holds an even number of ones.
  function automatic logic parity_even(input logic [WORD_WIDTH-1:0] word);
    return ~^word;
  endfunction
`endif

  state_t state_r;
  state_t state_s;
  beat_t  main_r;
  beat_t  skid_r;
  beat_t  in_beat_s;
  logic   m_valid_r;
  logic   s_ready_r;
  logic   cf_q_r;
  logic   zf_q_r;
  logic   sf_q_r;
`ifdef POLYSHIFT_R_FLAGS_STAGE_PF_EN
  logic   pf_q_r;
`endif
  logic   accept_s;
  logic   retire_s;
  logic   load_main_in_s;
  logic   load_main_skid_s;
  logic   load_skid_s;
  logic   commit_s;

  assign accept_s = bus.s_valid_i & s_ready_r;
  assign retire_s = m_valid_r & bus.m_ready_i;
  assign commit_s = retire_s & main_r.we;

  // Flags of the incoming word, computed at accept time.
  always_comb begin
    in_beat_s      = '0;
    in_beat_s.data = bus.s_data_i;
    in_beat_s.cf   = bus.s_cf_i;
    in_beat_s.zf   = (bus.s_data_i == {WORD_WIDTH{1'b0}});
    in_beat_s.sf   = bus.s_data_i[WORD_WIDTH-1];
    in_beat_s.we   = bus.s_flags_we_i;
`ifdef POLYSHIFT_R_FLAGS_STAGE_PF_EN
    in_beat_s.pf   = parity_even(bus.s_data_i);
`endif
  end

  // Occupancy next-state and buffer load selects.
  always_comb begin
    state_s          = state_r;
    load_main_in_s   = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          load_main_in_s = 1'b1;
          state_s        = ST_ONE;
        end else begin
          state_s        = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (accept_s && retire_s) begin
          load_main_in_s = 1'b1;
          state_s        = ST_ONE;
        end else if (retire_s) begin
          state_s        = ST_EMPTY;
        end else if (accept_s) begin
          load_skid_s    = 1'b1;
          state_s        = ST_TWO;
        end else begin
          state_s        = ST_ONE;
        end
      end
      ST_TWO: begin
        // s_ready is low here, so only a retire can move the state.
        if (retire_s) begin
          load_main_skid_s = 1'b1;
          state_s          = ST_ONE;
        end else begin
          state_s          = ST_TWO;
        end
      end
      default: begin
        state_s = ST_EMPTY;
      end
    endcase
  end

  // Occupancy state plus handshake outputs registered from the next state,
  // so s_ready never depends combinationally on m_ready.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r   <= ST_EMPTY;
      m_valid_r <= 1'b0;
      s_ready_r <= 1'b1;
    end else begin
      state_r   <= state_s;
      m_valid_r <= (state_s != ST_EMPTY);
      s_ready_r <= (state_s != ST_TWO);
    end
  end

  // Main and skid beat storage.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      main_r <= '0;
      skid_r <= '0;
    end else begin
      if (load_main_in_s) begin
        main_r <= in_beat_s;
      end else if (load_main_skid_s) begin
        main_r <= skid_r;
      end
      if (load_skid_s) begin
        skid_r <= in_beat_s;
      end
    end
  end

  // Architectural flag register, loaded by a retiring flag-writing beat.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cf_q_r <= 1'b0;
      zf_q_r <= 1'b0;
      sf_q_r <= 1'b0;
`ifdef POLYSHIFT_R_FLAGS_STAGE_PF_EN
      pf_q_r <= 1'b0;
`endif
    end else if (commit_s) begin
      cf_q_r <= main_r.cf;
      zf_q_r <= main_r.zf;
      sf_q_r <= main_r.sf;
`ifdef POLYSHIFT_R_FLAGS_STAGE_PF_EN
      pf_q_r <= main_r.pf;
`endif
    end
  end

  assign bus.s_ready_o = s_ready_r;
  assign bus.m_valid_o = m_valid_r;
  assign bus.m_data_o  = main_r.data;
  assign bus.m_cf_o    = main_r.cf;
  assign bus.m_zf_o    = main_r.zf;
  assign bus.m_sf_o    = main_r.sf;
  assign cf_q_o        = cf_q_r;
  assign zf_q_o        = zf_q_r;
  assign sf_q_o        = sf_q_r;
`ifdef POLYSHIFT_R_FLAGS_STAGE_PF_EN
  assign bus.m_pf_o    = main_r.pf;
  assign pf_q_o        = pf_q_r;
`endif

endmodule

// File: tb/tb_polyshift_r_flags_stage.sv
// tb_polyshift_r_flags_stage
// Directed bench for polyshift_r_flags_stage with WORD_WIDTH = 8. Inputs are
// driven and outputs sampled 1 ns after each rising edge.
module tb_polyshift_r_flags_stage;

  logic clk;
  logic rst_n;
  logic cf_q;
  logic zf_q;
  logic sf_q;
`ifdef POLYSHIFT_R_FLAGS_STAGE_PF_EN
  logic pf_q;
`endif
  int   checks_cnt;
  int   errors_cnt;

  polyshift_r_flags_stage_if #(.WORD_WIDTH(8)) bus_if ();

  polyshift_r_flags_stage #(.WORD_WIDTH(8)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus_if.slave),
    .cf_q_o  (cf_q),
    .zf_q_o  (zf_q),
`ifdef POLYSHIFT_R_FLAGS_STAGE_PF_EN
    .sf_q_o  (sf_q),
    .pf_q_o  (pf_q)
`else
    .sf_q_o  (sf_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt = checks_cnt + 1;
    if (obs !== exp) begin
      errors_cnt = errors_cnt + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic cf, input logic we);
    bus_if.s_valid_i    = v;
    bus_if.s_data_i     = d;
    bus_if.s_cf_i       = cf;
    bus_if.s_flags_we_i = we;
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input logic cf,
                           input logic zf, input logic sf);
    check_eq({tag, "_valid"}, {31'd0, bus_if.m_valid_o}, 32'd1);
    check_eq({tag, "_data"},  {24'd0, bus_if.m_data_o}, {24'd0, d});
    check_eq({tag, "_cf"},    {31'd0, bus_if.m_cf_o}, {31'd0, cf});
    check_eq({tag, "_zf"},    {31'd0, bus_if.m_zf_o}, {31'd0, zf});
    check_eq({tag, "_sf"},    {31'd0, bus_if.m_sf_o}, {31'd0, sf});
  endtask

  task automatic check_q(input string tag, input logic cf, input logic zf, input logic sf);
    check_eq({tag, "_cfq"}, {31'd0, cf_q}, {31'd0, cf});
    check_eq({tag, "_zfq"}, {31'd0, zf_q}, {31'd0, zf});
    check_eq({tag, "_sfq"}, {31'd0, sf_q}, {31'd0, sf});
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst_n = 1'b0;
    bus_if.m_ready_i = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    step();

    // Reset state
    check_eq("rst_valid", {31'd0, bus_if.m_valid_o}, 32'd0);
    check_eq("rst_ready", {31'd0, bus_if.s_ready_o}, 32'd1);
    check_eq("rst_data",  {24'd0, bus_if.m_data_o}, 32'd0);
    check_eq("rst_mflags", {29'd0, bus_if.m_cf_o, bus_if.m_zf_o, bus_if.m_sf_o}, 32'd0);
    check_q("rst", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();

    // Single beat: 0x00 cf=1 we=1
    bus_if.m_ready_i = 1'b1;
    drive(1'b1, 8'h00, 1'b1, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check_out("single", 8'h00, 1'b1, 1'b1, 1'b0);
`ifdef POLYSHIFT_R_FLAGS_STAGE_PF_EN
    check_eq("single_pf", {31'd0, bus_if.m_pf_o}, 32'd1);
`endif
    check_q("single_pre", 1'b0, 1'b0, 1'b0);
    step();
    check_q("single_post", 1'b1, 1'b1, 1'b0);
    check_eq("single_drain", {31'd0, bus_if.m_valid_o}, 32'd0);

    // Stream 0x81, 0x40, 0x01 at one beat per cycle, we=0
    drive(1'b1, 8'h81, 1'b0, 1'b0);
    step();
    check_out("strm0", 8'h81, 1'b0, 1'b0, 1'b1);
    check_eq("strm0_rdy", {31'd0, bus_if.s_ready_o}, 32'd1);
    drive(1'b1, 8'h40, 1'b0, 1'b0);
    step();
    check_out("strm1", 8'h40, 1'b0, 1'b0, 1'b0);
    check_eq("strm1_rdy", {31'd0, bus_if.s_ready_o}, 32'd1);
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    step();
    check_out("strm2", 8'h01, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    check_eq("strm_drain", {31'd0, bus_if.m_valid_o}, 32'd0);
    check_q("strm", 1'b1, 1'b1, 1'b0);

    // Flag hold: 0xF0 we=0 retires over cf=1 zf=1 sf=0
    drive(1'b1, 8'hF0, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check_out("hold", 8'hF0, 1'b0, 1'b0, 1'b1);
    step();
    check_eq("hold_drain", {31'd0, bus_if.m_valid_o}, 32'd0);
    check_q("hold", 1'b1, 1'b1, 1'b0);

    // Backpressure: 0x11, 0x22 absorbed, 0x33 refused while stalled
    bus_if.m_ready_i = 1'b0;
    drive(1'b1, 8'h11, 1'b0, 1'b1);
    step();
    check_out("bp0", 8'h11, 1'b0, 1'b0, 1'b0);
    check_eq("bp0_rdy", {31'd0, bus_if.s_ready_o}, 32'd1);
    drive(1'b1, 8'h22, 1'b1, 1'b1);
    step();
    check_eq("bp1_rdy", {31'd0, bus_if.s_ready_o}, 32'd0);
    check_eq("bp1_data", {24'd0, bus_if.m_data_o}, 32'h11);
    drive(1'b1, 8'h33, 1'b0, 1'b1);
    step();
    check_eq("bp2_rdy", {31'd0, bus_if.s_ready_o}, 32'd0);
    check_eq("bp2_data", {24'd0, bus_if.m_data_o}, 32'h11);
    check_q("bp_stall", 1'b1, 1'b1, 1'b0);
    bus_if.m_ready_i = 1'b1;
    step();
    check_out("bp3", 8'h22, 1'b1, 1'b0, 1'b0);
    check_eq("bp3_rdy", {31'd0, bus_if.s_ready_o}, 32'd1);
    check_q("bp3", 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check_out("bp4", 8'h33, 1'b0, 1'b0, 1'b0);
    check_q("bp4", 1'b1, 1'b0, 1'b0);
    step();
    check_eq("bp_drain", {31'd0, bus_if.m_valid_o}, 32'd0);
    check_q("bp5", 1'b0, 1'b0, 1'b0);

    // Parity beats: 0x07 we=1 cf=1, then 0x03 we=0
    drive(1'b1, 8'h07, 1'b1, 1'b1);
    step();
`ifdef POLYSHIFT_R_FLAGS_STAGE_PF_EN
    check_eq("pf07", {31'd0, bus_if.m_pf_o}, 32'd0);
    check_eq("pf07_q_pre", {31'd0, pf_q}, 32'd1);
`endif
    drive(1'b1, 8'h03, 1'b0, 1'b0);
    step();
    check_out("pf03", 8'h03, 1'b0, 1'b0, 1'b0);
    check_q("pf07", 1'b1, 1'b0, 1'b0);
`ifdef POLYSHIFT_R_FLAGS_STAGE_PF_EN
    check_eq("pf03", {31'd0, bus_if.m_pf_o}, 32'd1);
    check_eq("pf07_q", {31'd0, pf_q}, 32'd0);
`endif
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    check_q("pf03", 1'b1, 1'b0, 1'b0);
`ifdef POLYSHIFT_R_FLAGS_STAGE_PF_EN
    check_eq("pf03_q", {31'd0, pf_q}, 32'd0);
`endif

    // Mid-stream reset with two beats buffered
    bus_if.m_ready_i = 1'b0;
    drive(1'b1, 8'hAA, 1'b1, 1'b1);
    step();
    drive(1'b1, 8'h55, 1'b1, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("mr_full", {31'd0, bus_if.s_ready_o}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mr_valid", {31'd0, bus_if.m_valid_o}, 32'd0);
    check_eq("mr_ready", {31'd0, bus_if.s_ready_o}, 32'd1);
    check_eq("mr_mflags", {29'd0, bus_if.m_cf_o, bus_if.m_zf_o, bus_if.m_sf_o}, 32'd0);
    check_q("mr", 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    bus_if.m_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("mr_after", {31'd0, bus_if.m_valid_o}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
